// File: rtl/bin_to_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM states and
// decimal-range constants used by the converter and its nibble corrector.
package bin_to_bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Largest value representable on the 4-digit display
    localparam int unsigned MAX_DEC = 9999;

    // Digit shown on every position when the value does not fit
    localparam logic [3:0] BCD_OVF_DIGIT = 4'hF;

    // Width of the BCD accumulation field (four nibbles)
    localparam int unsigned BCD_W = 16;

    // Width of one BCD digit
    localparam int unsigned DIGIT_W = 4;

endpackage : bin_to_bcd_pkg

// File: rtl/bcd_add3.sv
// Combinational double-dabble nibble correction: a digit of 5 or more gets 3
// added so that the following left shift carries into the next decimal place.
//   in_i  : BCD digit before correction
//   out_o : corrected digit
module bcd_add3
    import bin_to_bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] in_i,
    output logic [DIGIT_W-1:0] out_o
);

    always_comb begin
        out_o = in_i;
        if (in_i >= DIGIT_W'(5)) begin
            out_o = in_i + DIGIT_W'(3);
        end
    end

endmodule : bcd_add3

// File: rtl/bin_to_bcd_4digit.sv
// Iterative binary-to-BCD converter feeding a 4-digit seven-segment display.
// One bit is consumed per clock; the four digit outputs and the overflow flag
// update together on the final shift so the display never sees a partial value.
//   clk, rst_n       : clock, asynchronous active-low reset
//   bin_in, start    : value to convert, accepted on start while not busy
//   busy             : conversion in progress
//   done             : one-cycle pulse when bcd0..bcd3 / ovf have just updated
//   ovf              : last converted value exceeded 9999 (digits show F)
//   bcd0..bcd3       : ones, tens, hundreds, thousands digits
module bin_to_bcd_4digit
    import bin_to_bcd_pkg::*;
#(
    parameter int unsigned BIN_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       bcd0,
    output logic [3:0]       bcd1,
    output logic [3:0]       bcd2,
    output logic [3:0]       bcd3
);

    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

    state_e             state_q;
    logic [SR_W-1:0]    sr_q;
    logic [SR_W-1:0]    sr_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_flag_q;
    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_next;

    logic               busy_q;
    logic               done_q;
    logic               ovf_q;
    logic [DIGIT_W-1:0] bcd0_q;
    logic [DIGIT_W-1:0] bcd1_q;
    logic [DIGIT_W-1:0] bcd2_q;
    logic [DIGIT_W-1:0] bcd3_q;

    // Correct all four digits in parallel ahead of the shift
    for (genvar g = 0; g < 4; g++) begin : g_add3
        bcd_add3 u_add3 (
            .in_i  (sr_q[BIN_W + DIGIT_W*g +: DIGIT_W]),
            .out_o (bcd_adj[DIGIT_W*g +: DIGIT_W])
        );
    end

    // Shift the corrected {bcd,bin} register left by one; the top BCD bit is
    // only lost for values that are flagged as overflow anyway
    assign sr_d     = {bcd_adj[BCD_W-2:0], sr_q[BIN_W-1:0], 1'b0};
    assign bcd_next = sr_d[SR_W-1 -: BCD_W];

    // Control FSM, shift datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            cnt_q      <= '0;
            ovf_flag_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            bcd0_q     <= '0;
            bcd1_q     <= '0;
            bcd2_q     <= '0;
            bcd3_q     <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        sr_q       <= {BCD_W'(0), bin_in};
                        cnt_q      <= CNT_W'(BIN_W - 1);
                        ovf_flag_q <= (32'(bin_in) > MAX_DEC);
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        if (ovf_flag_q) begin
                            bcd0_q <= BCD_OVF_DIGIT;
                            bcd1_q <= BCD_OVF_DIGIT;
                            bcd2_q <= BCD_OVF_DIGIT;
                            bcd3_q <= BCD_OVF_DIGIT;
                        end else begin
                            bcd0_q <= bcd_next[ 3: 0];
                            bcd1_q <= bcd_next[ 7: 4];
                            bcd2_q <= bcd_next[11: 8];
                            bcd3_q <= bcd_next[15:12];
                        end
                        ovf_q   <= ovf_flag_q;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign ovf  = ovf_q;
    assign bcd0 = bcd0_q;
    assign bcd1 = bcd1_q;
    assign bcd2 = bcd2_q;
    assign bcd3 = bcd3_q;

endmodule : bin_to_bcd_4digit

// File: tb/tb_bin_to_bcd_4digit.sv
// Self-checking bench for bin_to_bcd_4digit: directed cases plus random
// values compared against a decimal reference model.
module tb_bin_to_bcd_4digit;

    localparam int unsigned BIN_W = 14;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             start  = 1'b0;
    logic [BIN_W-1:0] bin_in = '0;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [3:0]       bcd0, bcd1, bcd2, bcd3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bin_to_bcd_4digit #(.BIN_W(BIN_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bin_in (bin_in),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .ovf    (ovf),
        .bcd0   (bcd0),
        .bcd1   (bcd1),
        .bcd2   (bcd2),
        .bcd3   (bcd3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: decimal digits by plain division, all-F when out of range
    function automatic logic [15:0] model_bcd(input int unsigned v);
        if (v > 9999) return 16'hFFFF;
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [15:0] shown();
        return {bcd3, bcd2, bcd1, bcd0};
    endfunction

    // Start a conversion at the current falling edge and wait for done;
    // returns at the falling edge where done is visible.
    task automatic convert(input int unsigned v, input bit disturb);
        int  lat;
        bit  got;
        bit  busy_ok;
        bin_in = BIN_W'(v);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        bin_in = BIN_W'($urandom);
        chk("busy_after_start", 32'(busy), 1);
        lat = 0;
        got = 1'b0;
        busy_ok = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            if (disturb && (i == 2 || i == 6)) begin
                start  = 1'b1;
                bin_in = BIN_W'(5678);
            end else begin
                start  = 1'b0;
                bin_in = BIN_W'($urandom);
            end
            @(negedge clk);
            lat++;
            if (done) got = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        start = 1'b0;
        if (!got) begin
            chk("done_timeout", 0, 1);
        end else begin
            chk("latency", 32'(lat), 32'(BIN_W));
            chk("busy_whole_conv", 32'(busy_ok), 1);
            chk("busy_at_done", 32'(busy), 0);
            chk("digits", 32'(shown()), 32'(model_bcd(v)));
            chk("ovf", 32'(ovf), 32'(v > 9999));
        end
    endtask

    // Idle for n cycles and confirm the display holds
    task automatic idle_hold(input int n, input int unsigned v);
        repeat (n) @(negedge clk);
        chk("hold_done", 32'(done), 0);
        chk("hold_busy", 32'(busy), 0);
        chk("hold_digits", 32'(shown()), 32'(model_bcd(v)));
        chk("hold_ovf", 32'(ovf), 32'(v > 9999));
    endtask

    initial begin
        int unsigned last;
        bit saw_done;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_digits", 32'(shown()), 0);
        rst_n = 1'b1;
        bin_in = BIN_W'(777);
        idle_hold(5, 0);

        // Directed conversions including range boundaries
        convert(1234, 1'b0);  idle_hold(2, 1234);
        convert(0, 1'b0);     idle_hold(1, 0);
        convert(9999, 1'b0);  idle_hold(1, 9999);
        convert(10000, 1'b0); idle_hold(1, 10000);
        convert(42, 1'b0);    idle_hold(1, 42);
        convert(16383, 1'b0); idle_hold(1, 16383);

        // Starts during busy are ignored
        convert(1234, 1'b1);  idle_hold(3, 1234);

        // Back-to-back: second start lands in the done cycle
        convert(1234, 1'b0);
        convert(5678, 1'b0);
        idle_hold(1, 5678);

        // Reset abort mid-conversion
        bin_in = BIN_W'(9876);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_ovf", 32'(ovf), 0);
        chk("abort_digits", 32'(shown()), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        chk("abort_no_done", 32'(saw_done), 0);
        chk("abort_digits_after", 32'(shown()), 0);

        // Random values, mixing back-to-back and idle gaps
        last = 0;
        for (int k = 0; k < 30; k++) begin
            last = $urandom_range(0, 16383);
            if (k % 5 == 0) last = $urandom_range(9990, 10010);
            convert(last, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) idle_hold($urandom_range(1, 3), last);
        end
        idle_hold(2, last);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_bin_to_bcd_4digit
